spi_slave_sync: RTL

Parametrised SPI slave that runs entirely in the system clock domain. SCLK, CS_N and MOSI are oversampled through synchronisers. Word width, clock polarity/phase and bit order are set at elaboration. It sits between an external SPI master and the fabric: received words are emitted as single-cycle strobes, and transmit words are accepted through a one-entry valid/ready holding buffer.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_sync.sv | 23 ++
 rtl/spi_slave_sync.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the oversampled SPI slave: mode encodings, FSM states
// and the head-bit selector used for MISO presentation.
package spi_pkg;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int MAX_WIDTH = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic head_bit(input logic [MAX_WIDTH-1:0] word, input int width,
                                      input bit msb_first);
        return msb_first ? word[width-1] : word[0];
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with a selectable reset value.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg <= {STAGES{RESET_VAL}};
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely in the clk domain: pins are oversampled, received words
// leave as single-cycle strobes, TX words enter through a one-entry holding buffer.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             frame_active
);
    localparam logic [1:0] MODE           = 2'((CPOL & 1) * 2 + (CPHA & 1));
    localparam bit         SAMPLE_ON_RISE = (MODE == SPI_MODE0) || (MODE == SPI_MODE3);
    localparam logic       SCLK_IDLE      = 1'(CPOL & 1);
    localparam int         CNT_W          = $clog2(WIDTH);
    localparam int         FLUSH_W        = $clog2(SYNC_STAGES + 1);
    localparam logic [2:0] SYNC_RESET     = {1'b0, 1'b1, SCLK_IDLE};

    logic [2:0] pin_raw;
    logic [2:0] pin_sync;
    logic       sclk_s, cs_n_s, mosi_s;

    assign pin_raw = {spi_mosi, spi_cs_n, spi_sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(SYNC_RESET[gi])) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (pin_raw[gi]),
                .q   (pin_sync[gi])
            );
        end
    endgenerate

    assign sclk_s = pin_sync[0];
    assign cs_n_s = pin_sync[1];
    assign mosi_s = pin_sync[2];

    state_t               state_reg, state_next;
    logic                 sclk_prev_reg;
    logic [FLUSH_W-1:0]   flush_cnt_reg;
    logic                 armed_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [WIDTH-1:0]     rx_sr_reg, tx_sr_reg, rx_data_reg, buf_reg;
    logic                 buf_full_reg, need_load_reg, rx_valid_reg, underrun_reg, miso_reg;

    logic sclk_rise, sclk_fall, sample_ev, shift_ev;
    logic flushed, start, stop, in_shift, do_load, capture;
    logic [WIDTH-1:0] load_word, rx_shifted;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    function automatic logic head(input logic [WIDTH-1:0] v);
        return head_bit(MAX_WIDTH'(v), WIDTH, MSB_FIRST != 0);
    endfunction

    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign sample_ev = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_ev  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

    // A frame may only start once CS_N has been seen high through a flushed synchroniser,
    // so a CS_N held low across reset never looks like a fresh falling edge.
    assign flushed  = (flush_cnt_reg == FLUSH_W'(SYNC_STAGES));
    assign start    = (state_reg == ST_IDLE) && armed_reg && !cs_n_s;
    assign stop     = (state_reg == ST_SHIFT) && cs_n_s;
    assign in_shift = (state_reg == ST_SHIFT) && !cs_n_s;
    assign do_load  = start || (in_shift && shift_ev && need_load_reg);
    assign capture  = tx_valid && !buf_full_reg;

    assign load_word  = buf_full_reg ? buf_reg : '0;
    assign rx_shifted = (MSB_FIRST != 0) ? {rx_sr_reg[WIDTH-2:0], mosi_s}
                                         : {mosi_s, rx_sr_reg[WIDTH-1:1]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (stop)  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            sclk_prev_reg <= SCLK_IDLE;
            flush_cnt_reg <= '0;
            armed_reg     <= 1'b0;
            bit_cnt_reg   <= '0;
            rx_sr_reg     <= '0;
            tx_sr_reg     <= '0;
            rx_data_reg   <= '0;
            buf_reg       <= '0;
            buf_full_reg  <= 1'b0;
            need_load_reg <= 1'b0;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            miso_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sclk_prev_reg <= sclk_s;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= do_load && !buf_full_reg;
            buf_full_reg  <= capture || (buf_full_reg && !do_load);
            if (capture) buf_reg <= tx_data;
            if (!flushed) flush_cnt_reg <= flush_cnt_reg + FLUSH_W'(1);

            if (start) armed_reg <= 1'b0;
            else if (state_reg == ST_IDLE && flushed && cs_n_s) armed_reg <= 1'b1;

            if (start) begin
                bit_cnt_reg   <= '0;
                rx_sr_reg     <= '0;
                need_load_reg <= 1'b0;
                tx_sr_reg     <= load_word;
                if (CPHA == 0) miso_reg <= head(load_word);
            end else if (stop) begin
                bit_cnt_reg   <= '0;
                rx_sr_reg     <= '0;
                need_load_reg <= 1'b0;
            end else if (in_shift) begin
                if (shift_ev) begin
                    // CPHA=0 presents the bit after moving; CPHA=1 presents, then moves.
                    if (need_load_reg) begin
                        need_load_reg <= 1'b0;
                        miso_reg      <= head(load_word);
                        tx_sr_reg     <= (CPHA == 0) ? load_word : advance(load_word);
                    end else if (CPHA == 0) begin
                        miso_reg  <= head(advance(tx_sr_reg));
                        tx_sr_reg <= advance(tx_sr_reg);
                    end else begin
                        miso_reg  <= head(tx_sr_reg);
                        tx_sr_reg <= advance(tx_sr_reg);
                    end
                end
                if (sample_ev) begin
                    rx_sr_reg <= rx_shifted;
                    if (bit_cnt_reg == CNT_W'(WIDTH - 1)) begin
                        rx_data_reg   <= rx_shifted;
                        rx_valid_reg  <= 1'b1;
                        bit_cnt_reg   <= '0;
                        need_load_reg <= 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign spi_miso     = miso_reg;
    assign spi_miso_oe  = (state_reg == ST_SHIFT);
    assign frame_active = (state_reg == ST_SHIFT);
    assign rx_data      = rx_data_reg;
    assign rx_valid     = rx_valid_reg;
    assign tx_ready     = !buf_full_reg;
    assign tx_underrun  = underrun_reg;

endmodule
